// File: rtl/apsr_update.sv
// Two-stage flag update: stage 1 holds the ALU op, the next non-held edge commits masked NZCV flags.
// Flags land one edge after accept; i_hold freezes stage 1 and drops o_ready; MSR writes override commits.
module apsr_update (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_use_carry,
  input  logic        i_shift_carry,
  input  logic [3:0]  i_set_mask,
  input  logic        i_hold,
  input  logic        i_msr_we,
  input  logic [3:0]  i_msr_data,
  output logic [31:0] o_result,
  output logic        o_result_valid,
  output logic [3:0]  o_apsr,
  output logic        o_pending
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  logic        r_s1_valid;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_use_carry;
  logic        r_shift_carry;
  logic [3:0]  r_mask;
  logic [3:0]  r_apsr;

  logic        w_accept;
  logic        w_commit;
  logic        w_is_arith;
  logic [31:0] w_b_eff;
  logic        w_cin;
  logic [32:0] w_sum;
  logic [31:0] w_result;
  logic        w_n;
  logic        w_z;
  logic        w_c;
  logic        w_v;
  logic [3:0]  w_new_flags;
  logic [3:0]  w_apsr_commit;

  assign o_ready  = !(r_s1_valid && i_hold);
  assign w_accept = i_valid && o_ready;
  assign w_commit = r_s1_valid && !i_hold;

  // SUB is a + ~b + cin, so a plain SUB carries in 1 and C=1 means no borrow.
  assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_b_eff    = (r_op == OP_SUB) ? ~r_b : r_b;
  assign w_cin      = r_use_carry ? r_apsr[1] : (r_op == OP_SUB);
  assign w_sum      = {1'b0, r_a} + {1'b0, w_b_eff} + {32'b0, w_cin};

  always_comb begin
    w_result = 32'b0;
    case (r_op)
      OP_AND:  w_result = r_a & r_b;
      OP_ADD:  w_result = w_sum[31:0];
      OP_SUB:  w_result = w_sum[31:0];
      OP_MOV:  w_result = r_b;
      default: w_result = 32'b0;
    endcase
  end

  assign w_n = w_result[31];
  assign w_z = (w_result == 32'b0);
  assign w_c = w_is_arith ? w_sum[32] : r_shift_carry;
  // Logical ops keep V: feeding back the live flag makes the mask irrelevant for it.
  assign w_v = w_is_arith ? ((r_a[31] == w_b_eff[31]) && (w_sum[31] != r_a[31])) : r_apsr[0];

  assign w_new_flags   = {w_n, w_z, w_c, w_v};
  assign w_apsr_commit = (w_new_flags & r_mask) | (r_apsr & ~r_mask);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_valid    <= 1'b0;
      r_op          <= OP_AND;
      r_a           <= 32'b0;
      r_b           <= 32'b0;
      r_use_carry   <= 1'b0;
      r_shift_carry <= 1'b0;
      r_mask        <= 4'b0;
      r_apsr        <= 4'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid    <= 1'b1;
        r_op          <= i_op;
        r_a           <= i_a;
        r_b           <= i_b;
        r_use_carry   <= i_use_carry;
        r_shift_carry <= i_shift_carry;
        r_mask        <= i_set_mask;
      end else if (w_commit) begin
        r_s1_valid <= 1'b0;
      end

      if (i_msr_we) begin
        r_apsr <= i_msr_data;
      end else if (w_commit) begin
        r_apsr <= w_apsr_commit;
      end
    end
  end

  assign o_result       = w_result;
  assign o_result_valid = r_s1_valid;
  assign o_apsr         = r_apsr;
  assign o_pending      = r_s1_valid && (|r_mask);

endmodule

// File: tb/tb_apsr_update.sv
// Directed bench for apsr_update: table of single ops with chained flags, then hold/MSR/reset sequences.
module tb_apsr_update;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_use_carry;
  logic        i_shift_carry;
  logic [3:0]  i_set_mask;
  logic        i_hold;
  logic        i_msr_we;
  logic [3:0]  i_msr_data;
  logic [31:0] o_result;
  logic        o_result_valid;
  logic [3:0]  o_apsr;
  logic        o_pending;

  apsr_update dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_use_carry(i_use_carry),
    .i_shift_carry(i_shift_carry), .i_set_mask(i_set_mask), .i_hold(i_hold),
    .i_msr_we(i_msr_we), .i_msr_data(i_msr_data), .o_result(o_result),
    .o_result_valid(o_result_valid), .o_apsr(o_apsr), .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        uc;
    logic        sc;
    logic [3:0]  mask;
    logic [31:0] res;
    logic [3:0]  apsr;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic uc, input logic sc, input logic [3:0] mask);
    i_valid       = 1'b1;
    i_op          = op;
    i_a           = a;
    i_b           = b;
    i_use_carry   = uc;
    i_shift_carry = sc;
    i_set_mask    = mask;
  endtask

  initial begin
    // op: 00 AND, 01 ADD, 10 SUB, 11 MOV; APSR chains from 0000 through the table
    vt[0]  = '{2'b01, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'b1111, 32'h80000000, 4'b1001};
    vt[1]  = '{2'b10, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 4'b1111, 32'h00000000, 4'b0110};
    vt[2]  = '{2'b10, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 4'b1111, 32'h00000000, 4'b0110};
    vt[3]  = '{2'b00, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 4'b1111, 32'h00000001, 4'b0000};
    vt[4]  = '{2'b01, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'b0001, 32'h00000000, 4'b0001};
    vt[5]  = '{2'b11, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 4'b1111, 32'h00000000, 4'b0111};
    vt[6]  = '{2'b01, 32'h00000001, 32'h00000002, 1'b1, 1'b0, 4'b1111, 32'h00000004, 4'b0000};
    vt[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0010, 32'hFFFFFFFE, 4'b0010};
    vt[8]  = '{2'b10, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 4'b0000, 32'hFFFFFFFE, 4'b0010};
    vt[9]  = '{2'b10, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 4'b1111, 32'h7FFFFFFF, 4'b0011};
    vt[10] = '{2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 4'b1100, 32'hF000F000, 4'b1011};
    vt[11] = '{2'b10, 32'h0000000A, 32'h00000003, 1'b1, 1'b0, 4'b1111, 32'h00000007, 4'b0010};
    vt[12] = '{2'b01, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0010, 32'h00000000, 4'b0000};
    vt[13] = '{2'b10, 32'h0000000A, 32'h00000003, 1'b1, 1'b0, 4'b1111, 32'h00000006, 4'b0010};

    i_reset = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
    i_use_carry = 1'b0; i_shift_carry = 1'b0; i_set_mask = 4'b0;
    i_hold = 1'b0; i_msr_we = 1'b0; i_msr_data = 4'b0;

    #3;
    chk("rst_apsr", {28'b0, o_apsr}, 32'h0);
    chk("rst_rvalid", {31'b0, o_result_valid}, 32'h0);
    chk("rst_pending", {31'b0, o_pending}, 32'h0);
    chk("rst_result", o_result, 32'h0);
    chk("rst_ready", {31'b0, o_ready}, 32'h1);
    tick();
    tick();
    i_reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].uc, vt[i].sc, vt[i].mask);
      tick();
      i_valid = 1'b0;
      chk($sformatf("v%0d_result", i), o_result, vt[i].res);
      chk($sformatf("v%0d_rvalid", i), {31'b0, o_result_valid}, 32'h1);
      chk($sformatf("v%0d_pending", i), {31'b0, o_pending}, {31'b0, |vt[i].mask});
      tick();
      chk($sformatf("v%0d_apsr", i), {28'b0, o_apsr}, {28'b0, vt[i].apsr});
      chk($sformatf("v%0d_pend_clr", i), {31'b0, o_pending}, 32'h0);
      chk($sformatf("v%0d_rvalid_clr", i), {31'b0, o_result_valid}, 32'h0);
    end

    // back-to-back accepts, APSR starts at 0010
    drive(2'b11, 32'h0, 32'h5, 1'b0, 1'b0, 4'b1111);
    tick();
    chk("b2b_res1", o_result, 32'h5);
    drive(2'b01, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 4'b1111);
    tick();
    i_valid = 1'b0;
    chk("b2b_apsr1", {28'b0, o_apsr}, 32'h0);
    chk("b2b_res2", o_result, 32'h0);
    chk("b2b_rvalid2", {31'b0, o_result_valid}, 32'h1);
    tick();
    chk("b2b_apsr2", {28'b0, o_apsr}, 32'h6);
    chk("b2b_rvalid_clr", {31'b0, o_result_valid}, 32'h0);

    // three held cycles with a competing op offered; it must not be taken
    drive(2'b01, 32'h1, 32'h1, 1'b0, 1'b0, 4'b1111);
    tick();
    i_hold = 1'b1;
    drive(2'b11, 32'h0, 32'd123, 1'b0, 1'b0, 4'b1111);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d_ready", c), {31'b0, o_ready}, 32'h0);
      chk($sformatf("hold%0d_apsr", c), {28'b0, o_apsr}, 32'h6);
      chk($sformatf("hold%0d_result", c), o_result, 32'h2);
      chk($sformatf("hold%0d_rvalid", c), {31'b0, o_result_valid}, 32'h1);
      tick();
    end
    chk("hold_end_apsr", {28'b0, o_apsr}, 32'h6);
    i_hold  = 1'b0;
    i_valid = 1'b0;
    tick();
    chk("hold_commit_apsr", {28'b0, o_apsr}, 32'h0);
    chk("hold_commit_rvalid", {31'b0, o_result_valid}, 32'h0);

    // standalone MSR
    i_msr_we = 1'b1; i_msr_data = 4'b0011;
    tick();
    i_msr_we = 1'b0;
    chk("msr_apsr", {28'b0, o_apsr}, 32'h3);

    // MSR on the commit edge of an op that would produce 0100
    drive(2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 4'b1111);
    tick();
    i_valid = 1'b0;
    chk("msrc_result", o_result, 32'h0);
    i_msr_we = 1'b1; i_msr_data = 4'b1010;
    tick();
    i_msr_we = 1'b0;
    chk("msrc_apsr", {28'b0, o_apsr}, 32'hA);
    chk("msrc_rvalid", {31'b0, o_result_valid}, 32'h0);

    // reset while an update is pending
    drive(2'b01, 32'h1, 32'h0, 1'b0, 1'b0, 4'b1111);
    tick();
    i_valid = 1'b0;
    chk("rp_pending", {31'b0, o_pending}, 32'h1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("rp_apsr", {28'b0, o_apsr}, 32'h0);
    chk("rp_pending_clr", {31'b0, o_pending}, 32'h0);
    chk("rp_rvalid", {31'b0, o_result_valid}, 32'h0);
    chk("rp_result", o_result, 32'h0);
    tick();
    i_reset = 1'b0;
    drive(2'b10, 32'h0, 32'h1, 1'b0, 1'b0, 4'b1111);
    tick();
    i_valid = 1'b0;
    chk("post_rst_rvalid", {31'b0, o_result_valid}, 32'h1);
    chk("post_rst_result", o_result, 32'hFFFFFFFF);
    chk("post_rst_apsr_hold", {28'b0, o_apsr}, 32'h0);
    tick();
    chk("post_rst_apsr", {28'b0, o_apsr}, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
